// File: rtl/xbar_arb_pkg.sv
// xbar_arb_pkg: shared FSM state type, clog2 helper and counter-width defaults for the slave arbiter
package xbar_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  localparam int MAX_OUT_DEF = 8;
  localparam int OUT_W_DEF = clog2(MAX_OUT_DEF + 1);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr_i; PAVANA_ARB_FIXED_PRIO_EN selects lowest-index-wins
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
`ifndef PAVANA_ARB_FIXED_PRIO_EN
  input  logic [IW-1:0] ptr_i,
`endif
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  always_comb begin
    idx_o = '0;
`ifdef PAVANA_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = IW'(i);
`else
    // Walk offsets downward so the smallest offset from ptr_i wins
    for (int i = N - 1; i >= 0; i--)
      if (req_i[IW'((int'(ptr_i) + i) % N)]) idx_o = IW'((int'(ptr_i) + i) % N);
`endif
    valid_o = |req_i;
    gnt_o = valid_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/xbar_slave_arbiter.sv
// xbar_slave_arbiter: arbitrates masters onto one slave port and pushes read tags in grant order
// Define PAVANA_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module xbar_slave_arbiter
  import xbar_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 4,
  parameter int TAG_WIDTH       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            req_i,
  input  logic [NUM_MASTERS-1:0]            we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_bi,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata_bi,
  output logic [NUM_MASTERS-1:0]            ack_o,
  output logic                              slv_req_o,
  output logic                              slv_we_o,
  output logic [ADDR_WIDTH-1:0]             slv_addr_bo,
  output logic [DATA_WIDTH-1:0]             slv_wdata_bo,
  input  logic                              slv_ack_i,
  input  logic                              tag_fifo_full_i,
  output logic                              tag_fifo_wrreq_o,
  output logic [TAG_WIDTH-1:0]              tag_fifo_wdata_o,
  input  logic                              resp_done_i
);
  localparam int IW = clog2(NUM_MASTERS);
  localparam int CW = clog2(MAX_OUTSTANDING + 1);
  state_e                  state_q, state_d;
  logic [IW-1:0]           gnt_q, gnt_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]           out_q, out_d;
  logic [NUM_MASTERS-1:0]  arb_gnt;
  logic [IW-1:0]           arb_idx;
  logic                    arb_valid, can_grant, accept, push, dec;
`ifndef PAVANA_ARB_FIXED_PRIO_EN
  logic [IW-1:0]           ptr_q, ptr_d;
`endif
  rr_arbiter #(.N(NUM_MASTERS), .IW(IW)) u_arb (
    .req_i  (req_i),
`ifndef PAVANA_ARB_FIXED_PRIO_EN
    .ptr_i  (ptr_q),
`endif
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .valid_o(arb_valid)
  );
  // Full and outstanding limit gate every grant, writes included
  assign can_grant        = arb_valid && !tag_fifo_full_i && (out_q < CW'(MAX_OUTSTANDING));
  assign accept           = (state_q == BUSY) && slv_ack_i;
  assign push             = accept && !we_q;
  assign dec              = resp_done_i && (out_q != '0);
  assign ack_o            = accept ? NUM_MASTERS'(1) << gnt_q : '0;
  assign slv_req_o        = state_q == BUSY;
  assign slv_we_o         = we_q;
  assign slv_addr_bo      = addr_q;
  assign slv_wdata_bo     = wdata_q;
  assign tag_fifo_wrreq_o = push;
  assign tag_fifo_wdata_o = TAG_WIDTH'(gnt_q);
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (state_q == IDLE && can_grant) begin
      state_d = BUSY;
      gnt_d   = arb_idx;
      we_d    = |(we_i & arb_gnt);
      addr_d  = addr_bi[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_d = wdata_bi[arb_idx*DATA_WIDTH +: DATA_WIDTH];
    end
    if (accept) state_d = IDLE;
    out_d = (push && !dec) ? out_q + 1'b1 : (!push && dec) ? out_q - 1'b1 : out_q;
`ifndef PAVANA_ARB_FIXED_PRIO_EN
    ptr_d = accept ? ((gnt_q == IW'(NUM_MASTERS - 1)) ? '0 : gnt_q + 1'b1) : ptr_q;
`endif
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      out_q   <= '0;
`ifndef PAVANA_ARB_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
`ifndef PAVANA_ARB_FIXED_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
endmodule

// File: doc/xbar_slave_arbiter.md
# xbar_slave_arbiter

Arbitrates up to NUM_MASTERS requesters onto one crossbar slave port and schedules the in-order response sequencer behind it. On every accepted read it pushes the granted master index, as a tag, into the sequencer's tag FIFO, so the sequencer returns out-of-order read data in grant order. It stops granting while the tag FIFO is full or the read-outstanding limit is reached.

## Interface
- NUM_MASTERS, 4: number of requesters, 2..16.
- TAG_WIDTH, 2: tag width; must be ≥ clog2(NUM_MASTERS).
- ADDR_WIDTH, 32: request address width.
- DATA_WIDTH, 32: write data width.
- MAX_OUTSTANDING, 8: maximum reads accepted but not yet completed.
- clk_i  in  1  single clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  NUM_MASTERS  per-master request; held until the matching ack_o.
- we_i  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read).
- addr_bi  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses; master m at bits [m*ADDR_WIDTH +: ADDR_WIDTH].
- wdata_bi  in  NUM_MASTERS*DATA_WIDTH  flattened write data.
- ack_o  out  NUM_MASTERS  one-hot, one-cycle accept pulse.
- slv_req_o  out  1  slave request.
- slv_we_o  out  1  slave write enable.
- slv_addr_bo  out  ADDR_WIDTH  slave address.
- slv_wdata_bo  out  DATA_WIDTH  slave write data.
- slv_ack_i  in  1  slave accepts the current request.
- tag_fifo_full_i  in  1  sequencer tag FIFO full.
- tag_fifo_wrreq_o  out  1  tag push strobe.
- tag_fifo_wdata_o  out  TAG_WIDTH  tag value: granted index, zero-extended.
- resp_done_i  in  1  one read response delivered (the sequencer's output write strobe).

## Operation
- FSM has two states, IDLE and BUSY.
- **IDLE → BUSY** when all of the following hold: any req_i is set, !tag_fifo_full_i, and outstanding < MAX_OUTSTANDING.
  - On that edge: grant index, we, address and wdata of the winner are registered.
  - The gating conditions apply to writes as well as reads.
- **BUSY:**
  - slv_req_o = 1, with slv_* driven from the registers.
  - On slv_ack_i = 1 (combinational in the same cycle):
    - ack_o[grant] = 1.
    - If the registered we = 0: tag_fifo_wrreq_o = 1 and tag_fifo_wdata_o = grant.
  - **BUSY → IDLE** on the edge after that cycle.
- **Round-robin:** the search starts at ptr. After each accept, ptr = grant + 1, wrapping NUM_MASTERS−1 → 0.
- **Outstanding counter** (width clog2(MAX_OUTSTANDING+1)):
  - +1 on a read accept.
  - −1 on resp_done_i.
  - Both in the same cycle: unchanged.
  - resp_done_i at 0: ignored; no underflow.
- Tag FIFO full is only checked at grant time. A read granted while the FIFO was not full always pushes; the sequencer FIFO depth must cover MAX_OUTSTANDING.
- A master that drops req_i while BUSY breaks the protocol; the block does not detect it.

## Timing
- **Reset values:** state IDLE, ptr 0, outstanding 0, all outputs 0, payload registers 0.
- **Reset asserted mid-transfer:** the in-flight request is abandoned immediately; no ack_o and no tag push.
- **Latency:** req_i high at edge N → slv_req_o high from edge N+1.
- **Minimum period:** 2 cycles per transfer (IDLE cycle + BUSY cycle), when slv_ack_i is immediate.
- **Hold:** slv_req_o and the payload stay stable in BUSY until slv_ack_i.
- **Release:** ack_o pulses exactly once per transfer. A master sees ack_o at edge K and must drop req_i for edge K+1, or it is re-arbitrated as a new request.
- **Tag push:** tag_fifo_wrreq_o coincides with the read accept cycle and never fires for writes.

## Configuration
- PAVANA_ARB_FIXED_PRIO_EN defined:
  - fixed priority; the lowest index wins.
  - ptr is removed.
- Undefined (default):
  - round-robin as above.
- All other behaviour is identical in both modes.

## Structure
- Shared package `xbar_arb_pkg`:
  - state enum (IDLE, BUSY).
  - clog2 helper function.
  - localparam for the outstanding-counter width.
- Sub-module `rr_arbiter`:
  - combinational.
  - inputs: request vector and ptr.
  - outputs: one-hot grant, grant index, any-valid.
  - fixed-priority variant selected by the macro inside it.

## Test plan
- Reset, then master 2 reads addr 0x40; slv_ack_i on the 1st BUSY cycle → slv_req_o high 1 cycle after req_i, ack_o = 4'b0100, tag push with value 2, outstanding = 1.
- Masters 0–3 all requesting reads continuously, with ptr = 0 → grant order 0,1,2,3,0 and tags pushed 0,1,2,3,0.
  - With PAVANA_ARB_FIXED_PRIO_EN: master 0 is granted each time and re-requests.
- Master 1 write, data 0xDEADBEEF; slave stalls 3 cycles → slv_req_o held 4 cycles with stable payload, one ack_o, no tag push, outstanding unchanged.
- 8 reads accepted with no resp_done_i → 9th request not granted (slv_req_o stays 0). One resp_done_i → grant on the next edge.
- tag_fifo_full_i = 1 with req_i = 4'b0001 → no grant. Full deasserted → BUSY on the next edge.
- Simultaneous read accept and resp_done_i at outstanding = 3 → stays 3. rst_i asserted during BUSY → all outputs 0 asynchronously; no ack_o, no tag push.
